// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a 2-entry {pc, ins} buffer and single outstanding request.
// Optional misaligned-redirect halt enabled by defining FETCH_MISALIGN_EN.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, FULL = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, FULL = 2'd2} state_t;
`endif

  state_t      state, state_nx;
  logic [1:0]  count, count_nx;
  logic [31:0] pc0, ins0, pc1, ins1;
  logic        discard;
  logic [31:0] pend_pc;
  logic [31:0] tgt;
  logic        bad;

  logic fire, held, pop, drop, push, room, wr_hi;

  assign fire  = imem_req & imem_ack;
  assign held  = imem_req & ~imem_ack;
  assign pop   = ins_valid & ins_ready;
  // A response is dropped if it belongs to a fetch stream already redirected away.
  assign drop  = fire & (discard | redirect);
  assign push  = fire & ~drop;
  assign wr_hi = (count == 2'd2) | ((count == 2'd1) & ~pop);

`ifdef FETCH_MISALIGN_EN
  assign tgt = redirect_pc;
  assign bad = redirect & (redirect_pc[1:0] != 2'b00);
`else
  assign tgt = redirect_pc & 32'hFFFF_FFFC;
  assign bad = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign ins       = ins0;
  assign ins_pc    = pc0;
  assign ins_valid = (count != 2'd0);

  always_comb begin
    count_nx = count + {1'b0, push} - {1'b0, pop};
    if (redirect) count_nx = 2'd0;
  end

  assign room = (count_nx != 2'd2);

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (held) state_nx = WAIT; else if (!room) state_nx = FULL;
      WAIT:    if (!held) state_nx = room ? FETCH : FULL;
      FULL:    if (room) state_nx = FETCH;
`ifdef FETCH_MISALIGN_EN
      HALT:    if (redirect) state_nx = held ? WAIT : FETCH;
`endif
      default: state_nx = FETCH;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (bad) state_nx = HALT;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      count     <= 2'd0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      discard   <= 1'b0;
      pend_pc   <= RESET_PC;
      pc0       <= 32'd0;
      ins0      <= 32'd0;
      pc1       <= 32'd0;
      ins1      <= 32'd0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      // An unacknowledged request is never withdrawn, even on entering HALT.
      imem_req <= held | (state_nx == FETCH) | (state_nx == WAIT);
      if (held) begin
        if (redirect) begin
          discard <= 1'b1;
          if (!bad) pend_pc <= tgt;
        end
      end else begin
        if (fire) discard <= 1'b0;
        if (redirect && !bad) imem_addr <= tgt;
        else if (fire && discard) imem_addr <= pend_pc;
        else if (push) imem_addr <= imem_addr + 32'd4;
      end
      if (pop) begin
        pc0  <= pc1;
        ins0 <= ins1;
      end
      if (push) begin
        if (wr_hi) begin
          pc1  <= imem_addr;
          ins1 <= imem_rdata;
        end else begin
          pc0  <= imem_addr;
          ins0 <= imem_rdata;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_err <= 1'b0;
    else      misalign_err <= bad;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against an instruction-stream model.
`default_nettype none

module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hff70_0293;
      32'h4:   return 32'h0070_0313;
      32'h8:   return 32'h4062_8233;
      default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] a);
`ifdef FETCH_MISALIGN_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  assign imem_rdata = imem_ack ? memfn(imem_addr) : 32'hDEAD_BEEF;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int pops = 0;

  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] p_addr = 32'd0;
  bit disc = 0, p_hold = 0, p_flush = 0, p_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; applies one cycle of inputs.
  task automatic cyc(input bit ack, input bit rdy, input bit rd, input logic [31:0] rpc);
    if (p_hold) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, p_addr);
    end
    if (p_flush) chk("flush_empty", 32'(ins_valid), 32'd0);
    if (p_lat) begin
      chk("latency_valid", 32'(ins_valid), 32'd1);
      chk("latency_pc", ins_pc, p_addr);
    end
    if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
`ifndef FETCH_MISALIGN_EN
    chk("misalign_tied", 32'(misalign_err), 32'd0);
`endif
    imem_ack = ack; ins_ready = rdy; redirect = rd; redirect_pc = rpc;
    if (ins_valid && rdy) begin
      chk("stream_pc", ins_pc, exp_pc);
      chk("stream_ins", ins, memfn(ins_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    p_lat   = imem_req && ack && !rd && !disc && !ins_valid;
    p_hold  = imem_req && !ack;
    p_addr  = imem_addr;
    p_flush = rd;
    if (imem_req && ack) disc = 0;
    if (rd) begin
      exp_pc = aligned(rpc);
      if (imem_req && !ack) disc = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; ins_ready = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC; disc = 0; p_hold = 0; p_flush = 0; p_lat = 0;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    do_reset();

    // Streaming with memory and decoder always ready.
    pops = 0;
    repeat (20) cyc(1, 1, 0, 0);
    chk("throughput", 32'(pops >= 9), 32'd1);

    // Reset in the middle of an outstanding request, then decoder backpressure.
    cyc(0, 1, 0, 0);
    do_reset();
    repeat (10) cyc(1, 0, 0, 0);
    chk("full_noreq", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(ins_valid), 32'd1);
    chk("full_head", ins_pc, 32'h0);
    pops = 0;
    repeat (6) cyc(1, 1, 0, 0);
    chk("drain_pops", 32'(pops >= 3), 32'd1);

    // Memory stall at address 8, then redirect while the 0xC request waits.
    do_reset();
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h8); i++) cyc(1, 1, 0, 0);
    chk("reach_8", imem_addr, 32'h8);
    repeat (3) cyc(0, 1, 0, 0);
    chk("stall_addr", imem_addr, 32'h8);
    cyc(1, 1, 0, 0);
    chk("stall_data_valid", 32'(ins_valid), 32'd1);
    chk("stall_data_pc", ins_pc, 32'h8);
    chk("stall_data_ins", ins, 32'h4062_8233);
    chk("next_addr_c", imem_addr, 32'hC);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h100);
    chk("wait_redir_addr", imem_addr, 32'hC);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 10 && !ins_valid; i++) cyc(1, 1, 0, 0);
    chk("redir_first", ins_pc, 32'h100);
    cyc(1, 1, 0, 0);
    chk("redir_second_valid", 32'(ins_valid), 32'd1);
    chk("redir_second", ins_pc, 32'h104);

`ifdef FETCH_MISALIGN_EN
    cyc(1, 1, 1, 32'h102);
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    cyc(1, 1, 0, 0);
    chk("misalign_once", 32'(misalign_err), 32'd0);
    repeat (3) begin
      chk("halt_noreq", 32'(imem_req), 32'd0);
      cyc(1, 1, 0, 0);
    end
    cyc(1, 1, 1, 32'h200);
    for (int i = 0; i < 10 && !ins_valid; i++) cyc(1, 1, 0, 0);
    chk("halt_exit_pc", ins_pc, 32'h200);
`endif

    // Randomized traffic against the stream model.
    for (int i = 0; i < 1500; i++) begin
      automatic logic [31:0] r = $urandom;
`ifdef FETCH_MISALIGN_EN
      r[1:0] = 2'b00;
`endif
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, r);
    end

    pops = 0;
    repeat (10) cyc(1, 1, 0, 0);
    chk("final_progress", 32'(pops >= 4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
